// File: rtl/bcd_decoder_pkg.sv
// Shared constants and types for the BCD-to-binary decoder.
//   DIGIT_W        : bits per packed BCD digit
//   NUM_DIGITS_DEF : default digit count per input word
//   BCD_MAX_DIGIT  : largest legal BCD digit value
//   state_e        : decoder FSM states
//   bcd_rsp_t      : result presented to the consumer
package bcd_decoder_pkg;

    localparam int DIGIT_W        = 4;
    localparam int NUM_DIGITS_DEF = 8;
    localparam int BCD_MAX_DIGIT  = 9;
    localparam int BIN_W          = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic             err;
    } bcd_rsp_t;

endpackage

// File: rtl/bcd_decoder_digit_mac.sv
// Combinational per-digit step: acc_next = acc*10 + digit, plus detection of
// a digit above the legal BCD range.
//   acc      : running binary accumulator
//   digit    : raw 4-bit digit (accumulated even when illegal)
//   acc_next : acc*10 + digit, 32-bit wrap
//   dig_err  : digit > 9
module bcd_digit_mac
    import bcd_decoder_pkg::*;
(
    input  logic [BIN_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [BIN_W-1:0]   acc_next,
    output logic               dig_err
);

    // x10 built from two shifts so no multiplier is inferred.
    assign acc_next = (acc << 3) + (acc << 1) + BIN_W'(digit);
    assign dig_err  = (digit > DIGIT_W'(BCD_MAX_DIGIT));

endmodule

// File: rtl/bcd_decoder.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first.
//   clk, rst_n           : clock, async active-low reset
//   in_bcd/in_valid      : packed BCD word, accepted only in IDLE (in_ready)
//   out_bin/out_err      : binary result and illegal-digit flag
//   out_valid/out_ready  : result handshake, held in DONE until accepted
module bcd_decoder
#(
    parameter int NUM_DIGITS = bcd_decoder_pkg::NUM_DIGITS_DEF
)(
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [bcd_decoder_pkg::DIGIT_W*NUM_DIGITS-1:0] in_bcd,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    output logic [bcd_decoder_pkg::BIN_W-1:0]          out_bin,
    output logic                                       out_err,
    output logic                                       out_valid,
    input  logic                                       out_ready
);

    import bcd_decoder_pkg::*;

    localparam int SR_W  = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS) + 1;

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sreg_q, sreg_d;
    logic [BIN_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    bcd_rsp_t           rsp_q, rsp_d;

    logic [BIN_W-1:0]   mac_acc;
    logic               mac_err;

    bcd_digit_mac u_mac (
        .acc      (acc_q),
        .digit    (sreg_q[SR_W-1 -: DIGIT_W]),
        .acc_next (mac_acc),
        .dig_err  (mac_err)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rsp_d   = rsp_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = in_bcd;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d  = mac_acc;
                err_d  = err_q | mac_err;
                sreg_d = sreg_q << DIGIT_W;
                cnt_d  = cnt_q + 1'b1;
                // Result register loads only on the edge into DONE so the
                // outputs never show partial sums.
                if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
                    rsp_d.bin = mac_acc;
                    rsp_d.err = err_q | mac_err;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bin   = rsp_q.bin;
    assign out_err   = rsp_q.err;

endmodule

// File: tb/tb_bcd_decoder.sv
// Directed + randomized bench for bcd_decoder against an arithmetic model.
module tb_bcd_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_bcd = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_bin;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    bcd_decoder #(.NUM_DIGITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bcd    (in_bcd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bin   (out_bin),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: weighted decimal sum of raw digit values, error if any > 9.
    function automatic logic [31:0] ref_bin(input logic [31:0] w);
        longint unsigned sum = 0;
        longint unsigned pw  = 1;
        for (int k = 0; k < 8; k++) begin
            sum += ((w >> (4 * k)) & 32'hF) * pw;
            pw  *= 10;
        end
        return 32'(sum);
    endfunction

    function automatic logic ref_err(input logic [31:0] w);
        for (int k = 0; k < 8; k++)
            if (((w >> (4 * k)) & 32'hF) > 9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; scribbles on the inputs during CONV/DONE and
    // holds out_ready low for `hold` cycles in DONE.
    task automatic run_word(input logic [31:0] w, input int hold, input string tag);
        int lat;
        logic [31:0] b0;
        logic        e0;
        chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_bcd   = w;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 30) begin
            in_valid = 1'($urandom);
            in_bcd   = $urandom;
            step();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd8);
        chk({tag, " out_bin"}, out_bin, ref_bin(w));
        chk({tag, " out_err"}, 32'(out_err), 32'(ref_err(w)));
        b0 = out_bin;
        e0 = out_err;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in_bcd   = $urandom;
            step();
            chk({tag, " hold stable"}, {out_bin[30:0] ^ b0[30:0], out_err ^ e0},
                32'd0);
            chk({tag, " hold valid/ready"}, {30'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid  = 1'b1;
        in_bcd    = $urandom;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, " exit to idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        int          last_acc;
        logic [31:0] expq[$];
        logic [31:0] e;

        // Reset state
        #2;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_bin", out_bin, 32'd0);
        chk("reset out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Directed words
        run_word(32'h1234_5678, 0, "w12345678");
        run_word(32'h9999_9999, 1, "w99999999");
        run_word(32'h0000_0000, 0, "w0");
        run_word(32'h0000_000A, 0, "w0000000A");
        run_word(32'hF000_0000, 0, "wF0000000");
        run_word(32'h0876_5432, 20, "hold20");

        // Reset mid-conversion, at digit 4
        in_bcd   = 32'h1234_5678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort out_bin", out_bin, 32'd0);
        chk("abort out_err", 32'(out_err), 32'd0);
        repeat (2) step();
        chk("abort held out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_word(32'h0000_0042, 0, "w42");

        // Randomized: half with legal digits, half fully random
        for (int n = 0; n < 24; n++) begin
            if (n[0]) w = $urandom;
            else begin
                w = '0;
                for (int k = 0; k < 8; k++) w = (w << 4) | 32'($urandom_range(0, 9));
            end
            run_word(w, int'($urandom_range(0, 3)), "rand");
        end

        // Continuous valid/ready: one word every 10 cycles
        in_bcd    = $urandom;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        last_acc  = -1;
        for (int c = 0; c < 45; c++) begin
            if (out_valid) begin
                e = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF;
                chk("stream out_bin", out_bin, e);
            end
            if (in_ready) begin
                if (last_acc >= 0) chk("stream period", 32'(c - last_acc), 32'd10);
                last_acc = c;
                expq.push_back(ref_bin(in_bcd));
            end
            step();
            if (!in_ready) in_bcd = $urandom;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
